// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS date/time alarms plus ring/snooze/dismiss FSM timed by tick_1s; ALARM_DAILY_EN selects daily hh:mm:ss alarms.
// Latency: match to ring 2 cycles, rd_sel to rd_time 1 cycle; no backpressure, all inputs are accepted every cycle.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1s,
  input  logic [51:0]           cur_time,
  input  logic                  wr_en,
  input  logic [3:0]            wr_sel,
  input  logic [51:0]           wr_time,
  input  logic                  wr_arm,
  input  logic                  clr_all,
  input  logic                  snooze,
  input  logic                  dismiss,
  input  logic [3:0]            rd_sel,
  output logic [51:0]           rd_time,
  output logic [NUM_ALARMS-1:0] armed,
  output logic                  ring,
  output logic [3:0]            ring_id,
  output logic                  snoozing
);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int NW = $clog2(MAX_SNOOZE + 1);
  localparam logic [RW-1:0] RING_LD = RW'(RING_SEC);
  localparam logic [SW-1:0] SNZ_LD  = SW'(SNOOZE_SEC);
  localparam logic [NW-1:0] SNZ_MAX = NW'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  state_t state, state_nxt;

  logic [51:0]           alarm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] pending;
  logic [NUM_ALARMS-1:0] match_ev;
  logic [51:0]           cur_q;
  logic [51:0]           rd_nxt;
  logic [RW-1:0]         ring_cnt;
  logic [SW-1:0]         snooze_cnt;
  logic [NW-1:0]         snz_cnt;
  logic [3:0]            pick;
  logic                  pend_any;
  logic                  time_chg;
  logic                  wr_ok;
  logic                  wr_hits_active;
  logic                  go_ring, go_snooze, rearm, do_dismiss, ring_dec, snz_dec;

`ifdef ALARM_DAILY_EN
  logic [27:0] last_date [NUM_ALARMS];
`endif

  assign time_chg       = (cur_time != cur_q);
  assign wr_ok          = wr_en && (32'(wr_sel) < NUM_ALARMS);
  assign wr_hits_active = wr_ok && (wr_sel == ring_id) && (state != IDLE);
  assign pend_any       = |pending;

  // The channel already being rung or snoozed never re-queues itself.
  always_comb begin
    match_ev = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
`ifdef ALARM_DAILY_EN
      match_ev[i] = armed[i] && time_chg && (cur_time[23:0] == alarm[i][23:0]) &&
                    (cur_time[51:24] != last_date[i]);
`else
      match_ev[i] = armed[i] && time_chg && (cur_time == alarm[i]);
`endif
      if ((state != IDLE) && (ring_id == 4'(i))) match_ev[i] = 1'b0;
    end
  end

  always_comb begin
    pick = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) pick = 4'(i);
    end
  end

  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_sel == 4'(i)) rd_nxt = alarm[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Within a state: dismiss beats snooze beats tick; a ring timeout acts as dismiss.
  always_comb begin
    state_nxt  = state;
    go_ring    = 1'b0;
    go_snooze  = 1'b0;
    rearm      = 1'b0;
    do_dismiss = 1'b0;
    ring_dec   = 1'b0;
    snz_dec    = 1'b0;
    if (clr_all || wr_hits_active) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pend_any) begin
            go_ring   = 1'b1;
            state_nxt = RINGING;
          end
        end
        RINGING: begin
          if (dismiss) begin
            do_dismiss = 1'b1;
            state_nxt  = IDLE;
          end else if (snooze && (snz_cnt < SNZ_MAX)) begin
            go_snooze = 1'b1;
            state_nxt = SNOOZE;
          end else if (tick_1s) begin
            if (ring_cnt <= RW'(1)) begin
              do_dismiss = 1'b1;
              state_nxt  = IDLE;
            end else begin
              ring_dec = 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            do_dismiss = 1'b1;
            state_nxt  = IDLE;
          end else if (tick_1s) begin
            if (snooze_cnt <= SW'(1)) begin
              rearm     = 1'b1;
              state_nxt = RINGING;
            end else begin
              snz_dec = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ring     = 1'b0;
    snoozing = 1'b0;
    case (state)
      RINGING: ring     = 1'b1;
      SNOOZE:  snoozing = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snz_cnt    <= '0;
      ring_id    <= '0;
    end else begin
      if (go_ring) begin
        ring_id  <= pick;
        ring_cnt <= RING_LD;
        snz_cnt  <= '0;
      end else if (rearm) begin
        ring_cnt <= RING_LD;
      end else if (ring_dec) begin
        ring_cnt <= ring_cnt - RW'(1);
      end
      if (go_snooze) begin
        snooze_cnt <= SNZ_LD;
        snz_cnt    <= snz_cnt + NW'(1);
      end else if (snz_dec) begin
        snooze_cnt <= snooze_cnt - SW'(1);
      end
    end
  end

  // Later assignments win: a write overrides match/dismiss on the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm[i] <= '0;
      armed   <= '0;
      pending <= '0;
      cur_q   <= '0;
      rd_time <= '0;
    end else begin
      cur_q   <= cur_time;
      rd_time <= rd_nxt;
      if (clr_all) begin
        armed   <= '0;
        pending <= '0;
      end else begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
          if (go_ring && (pick == 4'(i))) pending[i] <= 1'b0;
          if (match_ev[i])                pending[i] <= 1'b1;
`ifndef ALARM_DAILY_EN
          if (do_dismiss && (ring_id == 4'(i))) armed[i] <= 1'b0;
`endif
          if (wr_ok && (wr_sel == 4'(i))) begin
            alarm[i]   <= wr_time;
            armed[i]   <= wr_arm;
            pending[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef ALARM_DAILY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) last_date[i] <= '0;
    end else if (!clr_all) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (match_ev[i]) last_date[i] <= cur_time[51:24];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank with default parameters (4 channels, 30 s ring, 300 s snooze, 3 snoozes).
module tb_alarm_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1s;
  logic [51:0] cur_time;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [51:0] wr_time;
  logic        wr_arm;
  logic        clr_all;
  logic        snooze;
  logic        dismiss;
  logic [3:0]  rd_sel;
  logic [51:0] rd_time;
  logic [3:0]  armed;
  logic        ring;
  logic [3:0]  ring_id;
  logic        snoozing;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_bank dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1s  (tick_1s),
    .cur_time (cur_time),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_time  (wr_time),
    .wr_arm   (wr_arm),
    .clr_all  (clr_all),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .rd_sel   (rd_sel),
    .rd_time  (rd_time),
    .armed    (armed),
    .ring     (ring),
    .ring_id  (ring_id),
    .snoozing (snoozing)
  );

  always #5 clk = ~clk;

  function automatic logic [51:0] mk(int y, int mo, int d, int h, int mi, int s);
    return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] sel, input logic [51:0] t, input logic arm);
    wr_en = 1'b1; wr_sel = sel; wr_time = t; wr_arm = arm;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    cyc(1);
  endtask

  logic [51:0] ta, tb_, tc, td, te, tf, tg, th, ti;

  initial begin
    ta  = mk(2024, 3, 5, 7, 30, 0);
    tb_ = mk(2024, 3, 5, 7, 31, 0);
    tc  = mk(2024, 3, 5, 7, 32, 0);
    td  = mk(2024, 3, 5, 7, 33, 0);
    te  = mk(2024, 3, 5, 7, 34, 0);
    tf  = mk(2024, 3, 5, 7, 35, 0);
    tg  = mk(2024, 3, 5, 7, 36, 0);
    th  = mk(2024, 3, 5, 7, 37, 0);
    ti  = mk(2024, 3, 5, 7, 38, 0);

    rst = 1'b1; tick_1s = 1'b0; cur_time = mk(2024, 3, 5, 7, 29, 59);
    wr_en = 1'b0; wr_sel = '0; wr_time = '0; wr_arm = 1'b0;
    clr_all = 1'b0; snooze = 1'b0; dismiss = 1'b0; rd_sel = '0;
    cyc(2);
    rst = 1'b0;
    chk("rst_ring", ring, 0);
    chk("rst_ring_id", ring_id, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_armed", armed, 0);
    chk("rst_rd_time", rd_time, 0);

    // Out-of-range write is ignored
    wr(4'd7, ta, 1'b1);
    chk("wr_oob_armed", armed, 0);

    // ch2 write, readback latency and out-of-range readback
    wr(4'd2, ta, 1'b1);
    chk("wr2_armed", armed, 4'b0100);
    rd_sel = 4'd2;
    chk("rd_lat_before", rd_time, 0);
    cyc(1);
    chk("rd_ch2", rd_time, ta);
    rd_sel = 4'd5;
    cyc(1);
    chk("rd_oob", rd_time, 0);
    rd_sel = 4'd0;

    // ch2 match: ring two cycles after the time step
    cur_time = ta;
    cyc(1);
    chk("m2_ring_c1", ring, 0);
    cyc(1);
    chk("m2_ring_c2", ring, 1);
    chk("m2_ring_id", ring_id, 2);
    cyc(3);
    chk("m2_hold_ring", ring, 1);
    dismiss = 1'b1; cyc(1); dismiss = 1'b0;
    chk("m2_dismiss_ring", ring, 0);
    chk("m2_oneshot_armed", armed, 0);
    wr(4'd2, ta, 1'b1);
    cyc(3);
    chk("m2_no_retrigger", ring, 0);
    wr(4'd2, ta, 1'b0);

    // ch0 auto-dismiss after 30 ticks
    wr(4'd0, tb_, 1'b1);
    cur_time = tb_;
    cyc(2);
    chk("to_ring", ring, 1);
    chk("to_ring_id", ring_id, 0);
    repeat (29) tick();
    chk("to_ring_29", ring, 1);
    tick_1s = 1'b1; cyc(1); tick_1s = 1'b0;
    chk("to_ring_30", ring, 0);
    chk("to_armed", armed, 0);

    // ch1 snooze three times, fourth snooze ignored
    wr(4'd1, tc, 1'b1);
    cur_time = tc;
    cyc(2);
    chk("sz_ring", ring, 1);
    chk("sz_ring_id", ring_id, 1);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1; cyc(1); snooze = 1'b0;
      chk("sz_snoozing", snoozing, 1);
      chk("sz_ring_off", ring, 0);
      chk("sz_id_kept", ring_id, 1);
      repeat (299) tick();
      chk("sz_snoozing_299", snoozing, 1);
      tick_1s = 1'b1; cyc(1); tick_1s = 1'b0;
      chk("sz_rering", ring, 1);
      chk("sz_snoozing_off", snoozing, 0);
    end
    snooze = 1'b1; cyc(1); snooze = 1'b0;
    chk("sz4_ring", ring, 1);
    chk("sz4_snoozing", snoozing, 0);
    dismiss = 1'b1; cyc(1); dismiss = 1'b0;
    chk("sz_dismiss_ring", ring, 0);
    chk("sz_dismiss_armed", armed, 0);

    // ch0 and ch3 same second: ch0 first, one idle cycle, then ch3
    wr(4'd0, td, 1'b1);
    wr(4'd3, td, 1'b1);
    cur_time = td;
    cyc(2);
    chk("pri_ring", ring, 1);
    chk("pri_first_id", ring_id, 0);
    dismiss = 1'b1; cyc(1); dismiss = 1'b0;
    chk("pri_gap", ring, 0);
    cyc(1);
    chk("pri_second_ring", ring, 1);
    chk("pri_second_id", ring_id, 3);
    dismiss = 1'b1; cyc(1); dismiss = 1'b0;
    chk("pri_done_ring", ring, 0);
    chk("pri_done_armed", armed, 0);

    // Write to the ringing channel returns to idle
    wr(4'd1, te, 1'b1);
    cur_time = te;
    cyc(2);
    chk("wra_ring", ring, 1);
    wr(4'd1, te, 1'b0);
    chk("wra_ring_off", ring, 0);
    chk("wra_armed", armed, 0);
    cyc(2);
    chk("wra_stays_idle", ring, 0);

    // clr_all with three channels pending
    wr(4'd0, tf, 1'b1);
    wr(4'd1, tg, 1'b1);
    wr(4'd2, tg, 1'b1);
    wr(4'd3, tg, 1'b1);
    cur_time = tf;
    cyc(2);
    chk("clr_ring0", ring, 1);
    cur_time = tg;
    cyc(1);
    clr_all = 1'b1; cyc(1); clr_all = 1'b0;
    chk("clr_armed", armed, 0);
    chk("clr_ring", ring, 0);
    cyc(3);
    chk("clr_no_rings", ring, 0);

    // dismiss and snooze together: dismiss wins
    wr(4'd2, th, 1'b1);
    cur_time = th;
    cyc(2);
    chk("ds_ring", ring, 1);
    dismiss = 1'b1; snooze = 1'b1; cyc(1); dismiss = 1'b0; snooze = 1'b0;
    chk("ds_ring_off", ring, 0);
    chk("ds_snoozing", snoozing, 0);
    chk("ds_armed", armed, 0);

    // Reset in the middle of a snooze
    wr(4'd3, ti, 1'b1);
    cur_time = ti;
    cyc(2);
    snooze = 1'b1; cyc(1); snooze = 1'b0;
    chk("rs_snoozing", snoozing, 1);
    chk("rs_ring_id", ring_id, 3);
    rd_sel = 4'd3;
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("rs2_ring", ring, 0);
    chk("rs2_snoozing", snoozing, 0);
    chk("rs2_ring_id", ring_id, 0);
    chk("rs2_armed", armed, 0);
    chk("rs2_rd_time", rd_time, 0);
    cyc(1);
    chk("rs2_alarm_cleared", rd_time, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
